trap_sequencer: RTL and testbench

//  Machine-mode trap entry/exit sequencer. Detects ecall/ebreak/mret at decode and external

---
 rtl/trap_sequencer.sv | 131 +++++++++++++
 tb/tb_trap_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: holds the pipeline, writes mepc/mstatus/mcause, then redirects fetch.
// Optional feature: define TRAP_EBREAK_EN to make ebreak trap with EBREAK_CAUSE (otherwise ebreak passes as a nop).
module trap_sequencer #(
  parameter int          IRQ_W        = 8,
  parameter logic [31:0] IRQ_CAUSE    = 32'h8000_0007,
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_busy_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             hold_flag_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;
  localparam logic [31:0] CSR_MSTATUS  = 32'h300;
  localparam logic [31:0] CSR_MEPC     = 32'h341;
  localparam logic [31:0] CSR_MCAUSE   = 32'h342;

  typedef enum logic [2:0] {IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET_ST} state_t;

  state_t      state, state_next;
  logic [31:0] mepc_q, cause_q;
  logic        mret_q;

  logic is_ecall, is_ebreak, is_irq, is_mret, entry_req, trap_req;

  assign is_ecall  = (inst_i == INST_ECALL);
`ifdef TRAP_EBREAK_EN
  assign is_ebreak = (inst_i == INST_EBREAK);
`else
  assign is_ebreak = 1'b0;
`endif
  // An IRQ that is masked or blocked by a divide stays pending without raising hold.
  assign is_irq    = (|int_flag_i) && csr_mstatus_i[3] && !div_busy_i;
  assign is_mret   = (inst_i == INST_MRET);
  assign entry_req = is_ecall || is_ebreak || is_irq;
  assign trap_req  = !rst && (state == IDLE) && (entry_req || is_mret);

  assign hold_flag_o = !rst && ((state != IDLE) || trap_req);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mepc_q  <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (trap_req) begin
        mret_q <= !entry_req;
        if (is_ecall) begin
          mepc_q  <= inst_addr_i;
          cause_q <= ECALL_CAUSE;
        end else if (is_ebreak) begin
          mepc_q  <= inst_addr_i;
          cause_q <= EBREAK_CAUSE;
        end else if (is_irq) begin
          mepc_q  <= jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_q <= IRQ_CAUSE;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (trap_req) state_next = entry_req ? MEPC : MRET_ST;
      MEPC:    state_next = MSTATUS;
      MSTATUS: state_next = MCAUSE;
      MCAUSE:  state_next = ASSERT;
      MRET_ST: state_next = ASSERT;
      ASSERT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    unique case (state)
      MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = mepc_q;
      end
      MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
      end
      MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
      end
      MRET_ST: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer; expected values are hand-computed per vector.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_busy_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  trap_sequencer dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .div_busy_i(div_busy_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] inst, input logic [31:0] addr, input logic [7:0] irq,
                        input logic jf, input logic [31:0] ja, input logic db, input logic [31:0] ms);
    inst_i = inst; inst_addr_i = addr; int_flag_i = irq;
    jump_flag_i = jf; jump_addr_i = ja; div_busy_i = db; csr_mstatus_i = ms;
  endtask

  // Checks the current cycle's outputs, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic h, input logic w, input logic [31:0] wa,
                     input logic [31:0] d, input logic a, input logic [31:0] ia);
    #1;
    check({tag, ".hold"}, 32'(hold_flag_o), 32'(h));
    check({tag, ".we"}, 32'(we_o), 32'(w));
    check({tag, ".assert"}, 32'(int_assert_o), 32'(a));
    if (w) begin
      check({tag, ".waddr"}, waddr_o, wa);
      check({tag, ".data"}, data_o, d);
    end
    if (a) check({tag, ".int_addr"}, int_addr_o, ia);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    csr_mtvec_i = 32'h200;
    csr_mepc_i  = 32'h0;
    set_in(ECALL, 32'h100, 8'h01, 1'b0, 32'h0, 1'b0, 32'h8);
    @(posedge clk); #1;
    // Reset: pending ecall and IRQ must not raise hold while rst is high.
    #1;
    check("rst.hold", 32'(hold_flag_o), 32'd0);
    check("rst.we", 32'(we_o), 32'd0);
    check("rst.assert", 32'(int_assert_o), 32'd0);
    check("rst.waddr", waddr_o, 32'd0);
    check("rst.data", data_o, 32'd0);
    check("rst.int_addr", int_addr_o, 32'd0);
    set_in(NOP, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    @(posedge clk); #1;
    rst = 1'b0;

    // ecall at 0x100: 5 hold cycles, mepc/mstatus/mcause then redirect to mtvec.
    set_in(ECALL, 32'h100, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("ecall.det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h104, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("ecall.mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    cyc("ecall.mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc("ecall.mcause", 1, 1, 32'h342, 32'd11, 0, 0);
    cyc("ecall.assert", 1, 0, 0, 0, 1, 32'h200);
    cyc("ecall.done", 0, 0, 0, 0, 0, 0);

    // IRQ while execute redirects: mepc comes from jump_addr_i; IRQ drop mid-sequence is ignored.
    set_in(NOP, 32'h300, 8'h01, 1'b1, 32'h40, 1'b0, 32'h8);
    cyc("irq.det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h304, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("irq.mepc", 1, 1, 32'h341, 32'h40, 0, 0);
    cyc("irq.mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc("irq.mcause", 1, 1, 32'h342, 32'h8000_0007, 0, 0);
    cyc("irq.assert", 1, 0, 0, 0, 1, 32'h200);
    cyc("irq.done", 0, 0, 0, 0, 0, 0);

    // IRQ masked by MIE=0, then blocked by a divide: no hold, no write.
    set_in(NOP, 32'h300, 8'h01, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc("irq_masked", 0, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h300, 8'h01, 1'b0, 32'h0, 1'b1, 32'h8);
    for (int i = 0; i < 3; i++) cyc("irq_divbusy", 0, 0, 0, 0, 0, 0);

    // mret: mstatus 0x80 -> 0x88, redirect to mepc, 3 hold cycles.
    csr_mepc_i = 32'h104;
    set_in(MRET, 32'h220, 8'h00, 1'b0, 32'h0, 1'b0, 32'h80);
    cyc("mret.det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h224, 8'h00, 1'b0, 32'h0, 1'b0, 32'h80);
    cyc("mret.mstatus", 1, 1, 32'h300, 32'h88, 0, 0);
    cyc("mret.assert", 1, 0, 0, 0, 1, 32'h104);
    cyc("mret.done", 0, 0, 0, 0, 0, 0);

    // ecall and IRQ together: ecall wins; the still-pending IRQ is taken right after return.
    set_in(ECALL, 32'h100, 8'h01, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("both.det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h500, 8'h01, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("both.mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    cyc("both.mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc("both.mcause", 1, 1, 32'h342, 32'd11, 0, 0);
    cyc("both.assert", 1, 0, 0, 0, 1, 32'h200);
    cyc("both.irq_det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h504, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("both.irq_mepc", 1, 1, 32'h341, 32'h500, 0, 0);
    cyc("both.irq_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc("both.irq_mcause", 1, 1, 32'h342, 32'h8000_0007, 0, 0);
    cyc("both.irq_assert", 1, 0, 0, 0, 1, 32'h200);
    cyc("both.done", 0, 0, 0, 0, 0, 0);

    // ebreak: traps only when the optional decode is built in.
    set_in(EBREAK, 32'h180, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
`ifdef TRAP_EBREAK_EN
    cyc("ebreak.det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h184, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("ebreak.mepc", 1, 1, 32'h341, 32'h180, 0, 0);
    cyc("ebreak.mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc("ebreak.mcause", 1, 1, 32'h342, 32'd3, 0, 0);
    cyc("ebreak.assert", 1, 0, 0, 0, 1, 32'h200);
`else
    cyc("ebreak.nop", 0, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h184, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    for (int i = 0; i < 3; i++) cyc("ebreak.nop_after", 0, 0, 0, 0, 0, 0);
`endif
    cyc("ebreak.done", 0, 0, 0, 0, 0, 0);

    // Reset asserted during MSTATUS: back to IDLE, no mcause write or assert afterwards.
    set_in(ECALL, 32'h100, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("rstmid.det", 1, 0, 0, 0, 0, 0);
    set_in(NOP, 32'h104, 8'h00, 1'b0, 32'h0, 1'b0, 32'h8);
    cyc("rstmid.mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    rst = 1'b1;
    #1;
    check("rstmid.hold_in_rst", 32'(hold_flag_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc("rstmid.idle", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
